// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared constants for seq_calculator: opcode values, FSM state
//            encodings and bit positions inside the packed status-flag vector.
// Ports    : none (package)
// Config   : CALC_MUL_EN selects whether the MUL state is ever entered.
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

  // Opcodes
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Bit positions in the packed flag vector
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_ERR   = 3;
  localparam int FLAG_W     = 4;

endpackage
`default_nettype wire

// File: rtl/calc_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : calc_mul_iter
// Purpose  : Iterative shift-add multiplier. A start pulse loads a and b; one
//            bit of b is consumed per cycle for WIDTH cycles, after which done
//            is held high until the next start.
// Ports    : clk, rst (async, active-high), start, a, b
//            done, prod_lo (low WIDTH bits), prod_hi_nz (high half nonzero)
// Config   : only compiled when CALC_MUL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef CALC_MUL_EN
module calc_mul_iter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic             prod_hi_nz
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
      done_d   = 1'b0;
    end else if (busy_q) begin
      // Multiplicand walks left while the multiplier walks right, so the
      // current LSB of mplier_q always gates the correctly weighted term.
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign done       = done_q;
  assign prod_lo    = acc_q[WIDTH-1:0];
  assign prod_hi_nz = |acc_q[2*WIDTH-1:WIDTH];

endmodule
`endif
`default_nettype wire

// File: rtl/seq_calculator.sv
`default_nettype none
// ============================================================================
// Module   : seq_calculator
// Purpose  : Handshaked sequential calculator. Accepts {a, b, op} over a
//            valid/ready port, computes add/sub/and/or/xor/shl (one EXEC
//            cycle) or an iterative multiply, and presents a registered
//            result plus flags over a valid/ready output port.
// Ports    : clk, rst (async, active-high)
//            in_valid, in_ready, a, b, op       - command port
//            out_valid, out_ready, result,
//            carry, ovf, zero, err              - result port
// Config   : CALC_MUL_EN - instantiates calc_mul_iter and the MUL state;
//            when undefined op 110 is reported as a reserved opcode.
// Revision : 1.0 - initial release
// ============================================================================
module seq_calculator
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             err
);

  localparam int SH_W = $clog2(WIDTH);

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [FLAG_W-1:0] flags_q, flags_d;

  logic [WIDTH:0]    sum, diff;
  logic [WIDTH-1:0]  exec_res;
  logic [FLAG_W-1:0] exec_flags;

`ifdef CALC_MUL_EN
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_lo;
  logic             mul_hi_nz;

  // Multiplier loads straight from the input port on the accept edge so its
  // first iteration happens in the first MUL cycle.
  assign mul_start = (state_q == ST_IDLE) && in_valid && (op == OP_MUL);

  calc_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk        (clk),
    .rst        (rst),
    .start      (mul_start),
    .a          (a),
    .b          (b),
    .done       (mul_done),
    .prod_lo    (mul_lo),
    .prod_hi_nz (mul_hi_nz)
  );
`endif

  // Single-cycle datapath on the captured operands
  always_comb begin
    sum        = {1'b0, a_q} + {1'b0, b_q};
    diff       = {1'b0, a_q} - {1'b0, b_q};
    exec_res   = '0;
    exec_flags = '0;
    case (op_q)
      OP_ADD: begin
        exec_res               = sum[WIDTH-1:0];
        exec_flags[FLAG_CARRY] = sum[WIDTH];
        // Same-sign operands producing an opposite-sign sum
        exec_flags[FLAG_OVF]   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                 (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        exec_res               = diff[WIDTH-1:0];
        exec_flags[FLAG_CARRY] = diff[WIDTH];  // borrow out == (a < b)
        exec_flags[FLAG_OVF]   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                 (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: exec_res = a_q & b_q;
      OP_OR:  exec_res = a_q | b_q;
      OP_XOR: exec_res = a_q ^ b_q;
      OP_SHL: exec_res = a_q << b_q[SH_W-1:0];
      // OP_MUL only reaches EXEC when the multiplier is compiled out
      OP_MUL, OP_RSV: exec_flags[FLAG_ERR] = 1'b1;
    endcase
    exec_flags[FLAG_ZERO] = (exec_res == '0);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d  = a;
          b_d  = b;
          op_d = op;
`ifdef CALC_MUL_EN
          state_d = (op == OP_MUL) ? ST_MUL : ST_EXEC;
`else
          state_d = ST_EXEC;
`endif
        end
      end
      ST_EXEC: begin
        result_d = exec_res;
        flags_d  = exec_flags;
        state_d  = ST_DONE;
      end
`ifdef CALC_MUL_EN
      ST_MUL: begin
        if (mul_done) begin
          result_d              = mul_lo;
          flags_d               = '0;
          flags_d[FLAG_CARRY]   = mul_hi_nz;
          flags_d[FLAG_ZERO]    = (mul_lo == '0);
          state_d               = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry     = flags_q[FLAG_CARRY];
  assign ovf       = flags_q[FLAG_OVF];
  assign zero      = flags_q[FLAG_ZERO];
  assign err       = flags_q[FLAG_ERR];

endmodule
`default_nettype wire

// File: tb/tb_seq_calculator.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_calculator
// Purpose  : Directed self-checking bench for seq_calculator at WIDTH = 4.
//            Flag expectations are packed as {carry, ovf, zero, err}.
// Config   : CALC_MUL_EN selects the multiplier expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_calculator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic       carry;
  logic       ovf;
  logic       zero;
  logic       err;

  int vectors     = 0;
  int miscompares = 0;

  seq_calculator #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .ovf       (ovf),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, wait for out_valid, optional backpressure,
  // then handshake and confirm the block is ready again.
  task automatic run(input string tag, input logic [2:0] t_op,
                     input logic [3:0] t_a, input logic [3:0] t_b,
                     input logic [3:0] e_res, input logic [3:0] e_flg,
                     input int e_lat, input int hold);
    int lat;
    chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
    op = t_op; a = t_a; b = t_b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble operands right after the accept edge; they must already be held.
    in_valid = 1'b0; a = ~t_a; b = ~t_b; op = ~t_op;
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(e_lat));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;  // must be ignored outside IDLE
      chk({tag, ".hold_res"}, 32'({out_valid, in_ready, result}), 32'({2'b10, e_res}));
      chk({tag, ".hold_flg"}, 32'({carry, ovf, zero, err}), 32'(e_flg));
      step();
    end
    in_valid = 1'b0;
    chk({tag, ".res"}, 32'(result), 32'(e_res));
    chk({tag, ".flg"}, 32'({carry, ovf, zero, err}), 32'(e_flg));
    chk({tag, ".busy"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".ready_after"}, 32'({in_ready, out_valid}), 32'b10);
  endtask

  // Asynchronous reset pulse between clock edges, then confirm nothing emerges.
  task automatic reset_pulse(input string tag);
    bit seen;
    #1 rst = 1'b1;
    #1;
    chk({tag, ".outs"}, 32'({in_ready, out_valid, result, carry, ovf, zero, err}),
        32'({1'b1, 1'b0, 4'h0, 4'h0}));
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk({tag, ".no_valid"}, 32'(seen), 32'd0);
    chk({tag, ".idle"}, 32'({in_ready, result}), 32'({1'b1, 4'h0}));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    #7;
    chk("reset", 32'({in_ready, out_valid, result, carry, ovf, zero, err}),
        32'({1'b1, 1'b0, 4'h0, 4'h0}));
    #5 rst = 1'b0;
    step();

    run("add3p1",  3'b000, 4'd3,  4'd1, 4'd4,  4'b0000, 2, 0);
    run("add7p1",  3'b000, 4'd7,  4'd1, 4'd8,  4'b0100, 2, 0);
    run("add15p1", 3'b000, 4'd15, 4'd1, 4'd0,  4'b1010, 2, 0);
    run("add8p8",  3'b000, 4'd8,  4'd8, 4'd0,  4'b1110, 2, 0);
    run("sub4m1",  3'b001, 4'd4,  4'd1, 4'd3,  4'b0000, 2, 0);
    run("sub5m5",  3'b001, 4'd5,  4'd5, 4'd0,  4'b0010, 2, 0);
    run("sub8m1",  3'b001, 4'd8,  4'd1, 4'd7,  4'b0100, 2, 0);
    run("sub1m4",  3'b001, 4'd1,  4'd4, 4'd13, 4'b1000, 2, 0);

    // Abort during EXEC while the previous result (13, carry) is still held
    in_valid = 1'b1; a = 4'd7; b = 4'd1; op = 3'b000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    reset_pulse("rst_exec");

    run("and",    3'b010, 4'b1100, 4'b1010, 4'b1000, 4'b0000, 2, 0);
    run("or",     3'b011, 4'b1100, 4'b1010, 4'b1110, 4'b0000, 2, 0);
    run("xor",    3'b100, 4'b1100, 4'b1010, 4'b0110, 4'b0000, 2, 0);
    run("shl",    3'b101, 4'b0011, 4'b0110, 4'b1100, 4'b0000, 2, 0);
    run("shl_out",3'b101, 4'b0110, 4'b0111, 4'b0000, 4'b0010, 2, 0);

`ifdef CALC_MUL_EN
    run("mul3x5", 3'b110, 4'd3, 4'd5, 4'd15, 4'b0000, 6, 0);
    run("mul5x5", 3'b110, 4'd5, 4'd5, 4'd9,  4'b1000, 6, 0);
    // Abort mid-multiply: the pending product must never be presented
    in_valid = 1'b1; a = 4'd7; b = 4'd3; op = 3'b110;
    @(posedge clk);
    #1 in_valid = 1'b0;
    step();
    step();
    reset_pulse("rst_mul");
    run("mul_after_rst", 3'b110, 4'd4, 4'd4, 4'd0, 4'b1010, 6, 0);
`else
    run("mul_dis", 3'b110, 4'd3, 4'd5, 4'd0, 4'b0011, 2, 0);
`endif

    run("bp_add",  3'b000, 4'd2,  4'd3, 4'd5,  4'b0000, 2, 5);
    run("rsv",     3'b111, 4'd9,  4'd3, 4'd0,  4'b0011, 2, 0);
    run("add_post",3'b000, 4'd6,  4'd6, 4'd12, 4'b0100, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_calculator.md
# seq_calculator

Parametrised, handshaked calculator that is the sequential successor to the team's 4-bit combinational calculator. It accepts one operand pair and opcode per transaction over a valid/ready input port, computes add, subtract, logic, shift or an iterative multiply, and returns a registered result with status flags over a valid/ready output port. It sits between a command source and a result consumer in the Day-series datapath.

## Interface
Parameters:
- WIDTH, 4: operand and result width in bits, 2 to 32.

Ports:
- clk  in  1  rising-edge clock; the block has one clock.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  operand/opcode present.
- in_ready  out  1  block can accept a transaction.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 mul, 111 reserved.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  computed value.
- carry  out  1  add: carry-out; sub: borrow (a < b unsigned); mul: high half of product nonzero; else 0.
- ovf  out  1  signed overflow for add/sub; else 0.
- zero  out  1  result == 0.
- err  out  1  reserved opcode, or mul when the multiplier is compiled out.

## Operation
- FSM states: IDLE, EXEC, MUL, DONE.
- IDLE: in_ready = 1. When in_valid && in_ready, capture a, b, op. Go to MUL if op = 110 and the multiplier is present, otherwise go to EXEC.
- EXEC: compute the single-cycle op into the output registers, then go to DONE.
- MUL: shift-add, one bit of b per cycle, for exactly WIDTH cycles, then go to DONE.
- DONE: out_valid = 1. Outputs stay stable until out_ready = 1, then go to IDLE.
- Arithmetic is modulo 2^WIDTH.
- shl: a << b[$clog2(WIDTH)-1:0]. Upper bits of b are ignored.
- mul: result = low WIDTH bits of the 2·WIDTH product.
- Reserved opcode: result = 0, err = 1, zero = 1, carry = ovf = 0, with normal EXEC latency.
- Flags and result update together, only on entry to DONE.
- in_ready is 0 in EXEC, MUL and DONE. A new transaction can never start while the previous result is pending.

## Timing
- Reset values: in_ready = 1, out_valid = 0, result = 0, carry = ovf = zero = err = 0, state = IDLE.
- Single-cycle ops: out_valid rises 2 cycles after the accept edge (EXEC, then DONE).
- mul: out_valid rises WIDTH+2 cycles after the accept edge.
- Backpressure: while out_valid && !out_ready, all outputs hold for any number of cycles.
- in_ready returns to 1 in the cycle after the out_valid && out_ready handshake. Throughput is one transaction per 3 cycles at best.
- Reset asserted mid-transaction aborts immediately. All outputs take their reset values, the in-flight result is discarded and never presented.
- in_valid asserted outside IDLE has no effect. Operands are not sampled.

## Configuration
- CALC_MUL_EN defined: the iterative multiplier is instantiated and op 110 behaves as described above.
- CALC_MUL_EN undefined: no multiplier logic and no MUL state. Op 110 is treated as a reserved opcode (err = 1, result = 0, EXEC latency).

## Structure
- Package calc_pkg holds:
  - opcode constants OP_ADD … OP_RSV
  - FSM state encodings
  - flag bit positions
- Sub-module calc_mul_iter, parametrised on WIDTH:
  - inputs: start, a, b
  - outputs: done, prod_lo, prod_hi_nz
  - compiled only under CALC_MUL_EN.

## Test plan
All scenarios use WIDTH = 4.
- add 3+1 -> result 4, carry 0, ovf 0, zero 0, out_valid 2 cycles after accept. Then add 7+1 -> result 8, ovf 1. Then add 15+1 -> result 0, carry 1, zero 1.
- sub 4-1 -> result 3, carry 0. Then sub 1-4 -> result 13, carry 1.
- and 1100 & 1010 -> 1000. or -> 1110. xor -> 0110. shl 0011 by b = 0110 (low bits 2) -> 1100.
- mul 3·5 -> result 15, carry 0, latency 6. mul 5·5 -> result 9, carry 1.
  - With CALC_MUL_EN undefined: mul -> err 1, result 0.
- Backpressure and reset:
  - Hold out_ready = 0 for 5 cycles -> result and flags stable, in_ready 0. Release -> in_ready 1 the next cycle.
  - Pulse rst during MUL -> out_valid never rises, all outputs 0.
- op 111 with any operands -> err 1, result 0, zero 1.
